// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the command-frame controller: command bytes, FSM state codes
// and the result-byte sizing helper.
package sys_cmd_pkg;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU    = 8'hDD;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_OP_A     = 4'd5;
  localparam logic [3:0] ST_OP_B     = 4'd6;
  localparam logic [3:0] ST_ALU_FUN  = 4'd7;
  localparam logic [3:0] ST_ALU_WAIT = 4'd8;
  localparam logic [3:0] ST_TX_PUSH  = 4'd9;

  function automatic int res_bytes(input int alu_w, input int width);
    return (alu_w + width - 32'sd1) / width;
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command controller (master) and the RX sync / register file /
// ALU / TX FIFO surroundings (slave).
interface sys_cmd_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4,
  parameter int ALU_W  = 2 * WIDTH
);
  logic              RX_D_VLD;
  logic [WIDTH-1:0]  RX_P_DATA;
  logic [WIDTH-1:0]  RF_RD_DATA;
  logic              RF_RD_DATA_VLD;
  logic [ALU_W-1:0]  ALU_OUT;
  logic              ALU_OUT_VLD;
  logic              FIFO_FULL;
  logic              RF_WR_EN;
  logic              RF_RD_EN;
  logic [ADDR_W-1:0] RF_ADDR;
  logic [WIDTH-1:0]  RF_WR_DATA;
  logic              ALU_EN;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              CLK_GATE_EN;
  logic [WIDTH-1:0]  TX_P_DATA;
  logic              TX_D_VLD;
  logic              CLK_DIV_EN;
  logic              FRAME_ERR;

  modport master (
    input  RX_D_VLD, RX_P_DATA, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD, CLK_DIV_EN, FRAME_ERR
  );

  modport slave (
    output RX_D_VLD, RX_P_DATA, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD, CLK_DIV_EN, FRAME_ERR
  );

endinterface

// File: rtl/sys_cmd_tx_ser.sv
// Result latch and LSB-first byte serialiser into the TX FIFO; a byte is written only in
// a cycle where the FIFO reports not-full.
module sys_cmd_tx_ser #(
  parameter int WIDTH  = 8,
  parameter int NBYTES = 2,
  parameter int CNT_W  = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load_i,
  input  logic [CNT_W-1:0]        nbytes_i,
  input  logic [NBYTES*WIDTH-1:0] data_i,
  input  logic                    fifo_full_i,
  output logic [WIDTH-1:0]        tx_data_o,
  output logic                    tx_vld_o,
  output logic                    done_o
);

  logic                    busy_q, busy_d;
  logic [NBYTES*WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]        left_q, left_d;
  logic                    push_s;
  logic                    last_s;

  // The write strobe is gated by the live FIFO_FULL so a full FIFO is never written.
  assign push_s    = busy_q & ~fifo_full_i;
  assign last_s    = (left_q == CNT_W'(1));
  assign tx_data_o = data_q[WIDTH-1:0];
  assign tx_vld_o  = push_s;
  assign done_o    = push_s & last_s;

  // Next-state for the byte shifter and remaining-byte count.
  always_comb begin
    busy_d = busy_q;
    data_d = data_q;
    left_d = left_q;
    if (load_i) begin
      busy_d = 1'b1;
      data_d = data_i;
      left_d = nbytes_i;
    end else if (push_s) begin
      busy_d = ~last_s;
      data_d = data_q >> WIDTH;
      left_d = left_q - CNT_W'(1);
    end else begin
      busy_d = busy_q;
    end
  end

  // Serialiser registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= 1'b0;
      data_q <= '0;
      left_q <= '0;
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: decodes RX frames into register-file and ALU accesses and
// streams results into the TX FIFO. Frame timeout enabled by SYS_CMD_CTRL_TIMEOUT_EN.
module sys_cmd_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int ALU_W       = 2 * WIDTH,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic            CLK,
  input logic            RST,
  sys_cmd_ctrl_if.master bus
);

  localparam int RES_BYTES = res_bytes(ALU_W, WIDTH);
  localparam int SER_W     = RES_BYTES * WIDTH;
  localparam int CNT_W     = $clog2(RES_BYTES + 1);

  logic [3:0]        state_q, state_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic              alu_en_q, alu_en_d;
  logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic              clk_gate_en_q, clk_gate_en_d;
  logic              frame_err_q, frame_err_d;
  logic              clk_div_en_q;

  logic              rx_vld_s;
  logic [WIDTH-1:0]  rx_byte_s;
  logic              ser_load_s;
  logic [CNT_W-1:0]  ser_nbytes_s;
  logic [SER_W-1:0]  ser_data_s;
  logic              ser_done_s;
  logic              tmo_fire_s;

  assign rx_vld_s  = bus.RX_D_VLD;
  assign rx_byte_s = bus.RX_P_DATA;

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_frame_s;

  // Only states that are waiting for the next byte of a frame are timed.
  assign in_frame_s = (state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                       ST_OP_A, ST_OP_B, ST_ALU_FUN});
  assign tmo_fire_s = in_frame_s & ~rx_vld_s & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter, cleared by every accepted byte and outside frames.
  always_comb begin
    tmo_d = '0;
    if (in_frame_s && !rx_vld_s && !tmo_fire_s) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  // Frame decode FSM and registered strobe generation.
  always_comb begin
    state_d       = state_q;
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    rf_addr_d     = rf_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    alu_en_d      = 1'b0;
    alu_fun_d     = alu_fun_q;
    clk_gate_en_d = clk_gate_en_q;
    frame_err_d   = 1'b0;
    ser_load_s    = 1'b0;
    ser_nbytes_s  = '0;
    ser_data_s    = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_vld_s) begin
          case (rx_byte_s)
            WIDTH'(CMD_WR):     state_d = ST_WR_ADDR;
            WIDTH'(CMD_RD):     state_d = ST_RD_ADDR;
            WIDTH'(CMD_ALU_OP): state_d = ST_OP_A;
            WIDTH'(CMD_ALU):    state_d = ST_ALU_FUN;
            default:            state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (rx_vld_s) begin
          rf_addr_d = rx_byte_s[ADDR_W-1:0];
          state_d   = ST_WR_DATA;
        end else begin
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_DATA: begin
        if (rx_vld_s) begin
          rf_wr_data_d = rx_byte_s;
          rf_wr_en_d   = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_ADDR: begin
        if (rx_vld_s) begin
          rf_addr_d  = rx_byte_s[ADDR_W-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = ST_RD_WAIT;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_WAIT: begin
        if (bus.RF_RD_DATA_VLD) begin
          ser_load_s   = 1'b1;
          ser_nbytes_s = CNT_W'(1);
          ser_data_s   = SER_W'(bus.RF_RD_DATA);
          state_d      = ST_TX_PUSH;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      // Operands land in registers 0 and 1 before the function byte.
      ST_OP_A: begin
        if (rx_vld_s) begin
          rf_addr_d    = ADDR_W'(0);
          rf_wr_data_d = rx_byte_s;
          rf_wr_en_d   = 1'b1;
          state_d      = ST_OP_B;
        end else begin
          state_d = ST_OP_A;
        end
      end
      ST_OP_B: begin
        if (rx_vld_s) begin
          rf_addr_d    = ADDR_W'(1);
          rf_wr_data_d = rx_byte_s;
          rf_wr_en_d   = 1'b1;
          state_d      = ST_ALU_FUN;
        end else begin
          state_d = ST_OP_B;
        end
      end
      ST_ALU_FUN: begin
        if (rx_vld_s) begin
          alu_fun_d     = rx_byte_s[FUN_W-1:0];
          alu_en_d      = 1'b1;
          clk_gate_en_d = 1'b1;
          state_d       = ST_ALU_WAIT;
        end else begin
          state_d = ST_ALU_FUN;
        end
      end
      ST_ALU_WAIT: begin
        if (bus.ALU_OUT_VLD) begin
          ser_load_s    = 1'b1;
          ser_nbytes_s  = CNT_W'(RES_BYTES);
          ser_data_s    = SER_W'(bus.ALU_OUT);
          clk_gate_en_d = 1'b0;
          state_d       = ST_TX_PUSH;
        end else begin
          state_d = ST_ALU_WAIT;
        end
      end
      ST_TX_PUSH: begin
        if (ser_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX_PUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_fire_s) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = 1'b0;
    end
  end

  // Controller state and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      frame_err_q   <= 1'b0;
      clk_div_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      frame_err_q   <= frame_err_d;
      clk_div_en_q  <= 1'b1;
    end
  end

  sys_cmd_tx_ser #(
    .WIDTH  (WIDTH),
    .NBYTES (RES_BYTES),
    .CNT_W  (CNT_W)
  ) u_tx_ser (
    .CLK         (CLK),
    .RST         (RST),
    .load_i      (ser_load_s),
    .nbytes_i    (ser_nbytes_s),
    .data_i      (ser_data_s),
    .fifo_full_i (bus.FIFO_FULL),
    .tx_data_o   (bus.TX_P_DATA),
    .tx_vld_o    (bus.TX_D_VLD),
    .done_o      (ser_done_s)
  );

  assign bus.RF_WR_EN    = rf_wr_en_q;
  assign bus.RF_RD_EN    = rf_rd_en_q;
  assign bus.RF_ADDR     = rf_addr_q;
  assign bus.RF_WR_DATA  = rf_wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.CLK_GATE_EN = clk_gate_en_q;
  assign bus.CLK_DIV_EN  = clk_div_en_q;
  assign bus.FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: directed frames plus randomized frames scored
// against a transaction-level model of expected RF, ALU and TX activity.
module tb_sys_cmd_ctrl;

  localparam int WIDTH       = 8;
  localparam int ADDR_W      = 4;
  localparam int FUN_W       = 4;
  localparam int ALU_W       = 16;
  localparam int TIMEOUT_CYC = 4096;
  localparam int RESB        = (ALU_W + 7) / 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  sys_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .ALU_W(ALU_W)) bus ();

  sys_cmd_ctrl #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .ALU_W(ALU_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] act_wr[$], act_rd[$], act_alu[$], act_tx[$];
  logic [15:0] exp_wr[$], exp_rd[$], exp_alu[$], exp_tx[$];
  logic [7:0]  rd_data_q[$];
  logic [15:0] alu_res_q[$];

  int rx_cyc, wr_cyc, rd_en_cyc, rdvld_cyc, alu_en_cyc, aluvld_cyc, tx_cyc_first;
  int err_cnt = 0, err_cyc = 0, gate_cnt = 0;
  int full_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, bus.RF_WR_EN, bus.RF_RD_EN, bus.RF_ADDR, bus.RF_WR_DATA, bus.ALU_EN,
            bus.ALU_FUN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD, bus.CLK_DIV_EN,
            bus.FRAME_ERR};
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Output monitor: turns DUT strobes into transaction records.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      if (bus.RX_D_VLD) rx_cyc = cyc;
      if (bus.RF_WR_EN) begin
        act_wr.push_back({4'h0, bus.RF_ADDR, bus.RF_WR_DATA});
        wr_cyc = cyc;
      end
      if (bus.RF_RD_EN) begin
        act_rd.push_back({12'h000, bus.RF_ADDR});
        rd_en_cyc = cyc;
      end
      if (bus.RF_RD_DATA_VLD) rdvld_cyc = cyc;
      if (bus.ALU_EN) begin
        act_alu.push_back({12'h000, bus.ALU_FUN});
        alu_en_cyc = cyc;
      end
      if (bus.ALU_OUT_VLD) aluvld_cyc = cyc;
      if (bus.CLK_GATE_EN) gate_cnt++;
      if (bus.TX_D_VLD) begin
        chk("no_push_when_full", {31'd0, bus.FIFO_FULL}, 32'd0);
        if (act_tx.size() == 0) tx_cyc_first = cyc;
        act_tx.push_back({8'h00, bus.TX_P_DATA});
      end
      if (bus.FRAME_ERR) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Register-file read responder.
  initial begin
    bus.RF_RD_DATA_VLD = 1'b0;
    bus.RF_RD_DATA     = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST && bus.RF_RD_EN) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
        if (rd_data_q.size() > 0) bus.RF_RD_DATA = rd_data_q.pop_front();
        else bus.RF_RD_DATA = 8'h00;
        bus.RF_RD_DATA_VLD = 1'b1;
        @(posedge CLK);
        #1;
        bus.RF_RD_DATA_VLD = 1'b0;
      end
    end
  end

  // ALU responder.
  initial begin
    bus.ALU_OUT_VLD = 1'b0;
    bus.ALU_OUT     = 16'h0000;
    forever begin
      @(negedge CLK);
      if (RST && bus.ALU_EN) begin
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1;
        if (alu_res_q.size() > 0) bus.ALU_OUT = alu_res_q.pop_front();
        else bus.ALU_OUT = 16'h0000;
        bus.ALU_OUT_VLD = 1'b1;
        @(posedge CLK);
        #1;
        bus.ALU_OUT_VLD = 1'b0;
      end
    end
  end

  // TX FIFO full driver: 0 never full, 1 always full, otherwise random.
  initial begin
    bus.FIFO_FULL = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (full_mode)
        0:       bus.FIFO_FULL = 1'b0;
        1:       bus.FIFO_FULL = 1'b1;
        default: bus.FIFO_FULL = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic clr();
    act_wr.delete(); act_rd.delete(); act_alu.delete(); act_tx.delete();
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
  endtask

  task automatic wait_sync(input string tag);
    int t;
    t = 0;
    while (t < 400 && !(act_wr.size() == exp_wr.size() && act_rd.size() == exp_rd.size() &&
                        act_alu.size() == exp_alu.size() && act_tx.size() == exp_tx.size())) begin
      @(negedge CLK);
      t++;
    end
    chk(tag, {31'd0, (t < 400)}, 32'd1);
    repeat (2) @(posedge CLK);
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_wr_cnt"}, act_wr.size(), exp_wr.size());
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) chk({tag, "_wr"}, act_wr[i], exp_wr[i]);
    chk({tag, "_rd_cnt"}, act_rd.size(), exp_rd.size());
    for (int i = 0; i < act_rd.size() && i < exp_rd.size(); i++) chk({tag, "_rd"}, act_rd[i], exp_rd[i]);
    chk({tag, "_alu_cnt"}, act_alu.size(), exp_alu.size());
    for (int i = 0; i < act_alu.size() && i < exp_alu.size(); i++) chk({tag, "_alu"}, act_alu[i], exp_alu[i]);
    chk({tag, "_tx_cnt"}, act_tx.size(), exp_tx.size());
    for (int i = 0; i < act_tx.size() && i < exp_tx.size(); i++) chk({tag, "_tx"}, act_tx[i], exp_tx[i]);
  endtask

  function automatic logic [7:0] rand_cmd();
    case ($urandom_range(0, 3))
      0:       return 8'hAA;
      1:       return 8'hBB;
      2:       return 8'hCC;
      default: return 8'hDD;
    endcase
  endfunction

  logic [7:0]  fa, fb, fd, fn, fr;
  logic [15:0] fv;
  int          kind;

  initial begin
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs(), 32'd0);
    @(posedge CLK); #1; RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("clk_div_en", {31'd0, bus.CLK_DIV_EN}, 32'd1);

    // Register write
    clr();
    exp_wr.push_back(16'h053C);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    wait_sync("wr_sync");
    cmp_queues("wr");
    chk("wr_latency", wr_cyc, rx_cyc + 1);

    // Register read
    clr();
    rd_data_q.push_back(8'h7E);
    exp_rd.push_back(16'h0002);
    exp_tx.push_back(16'h007E);
    send_byte(8'hBB); send_byte(8'h02);
    wait_sync("rd_sync");
    cmp_queues("rd");
    chk("rd_en_latency", rd_en_cyc, rx_cyc + 1);
    chk("rd_tx_latency", tx_cyc_first, rdvld_cyc + 1);

    // ALU with operands
    clr();
    gate_cnt = 0;
    alu_res_q.push_back(16'h00C8);
    exp_wr.push_back(16'h000A); exp_wr.push_back(16'h0114);
    exp_alu.push_back(16'h0002);
    exp_tx.push_back(16'h00C8); exp_tx.push_back(16'h0000);
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h14); send_byte(8'h02);
    wait_sync("alu_sync");
    cmp_queues("alu");
    chk("alu_en_latency", alu_en_cyc, rx_cyc + 1);
    chk("clk_gate_span", gate_cnt, aluvld_cyc - alu_en_cyc + 1);
    chk("clk_gate_low", {31'd0, bus.CLK_GATE_EN}, 32'd0);
    chk("alu_fun_hold", {28'd0, bus.ALU_FUN}, 32'd2);

    // ALU without operands under FIFO_FULL backpressure
    clr();
    full_mode = 1;
    repeat (2) @(posedge CLK);
    fv = 16'($urandom);
    alu_res_q.push_back(fv);
    exp_alu.push_back(16'h0001);
    for (int i = 0; i < RESB; i++) exp_tx.push_back({8'h00, 8'(fv >> (8 * i))});
    send_byte(8'hDD); send_byte(8'h01);
    repeat (20) @(negedge CLK);
    chk("full_stall_tx", act_tx.size(), 0);
    full_mode = 0;
    wait_sync("full_sync");
    cmp_queues("full");

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
    // Inter-byte timeout
    clr();
    err_cnt = 0;
    send_byte(8'hAA); send_byte(8'h03);
    for (int t = 0; t < TIMEOUT_CYC + 20 && err_cnt == 0; t++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    chk("tmo_err_pulses", err_cnt, 1);
    chk("tmo_err_window", {31'd0, (err_cyc - rx_cyc >= TIMEOUT_CYC) && (err_cyc - rx_cyc <= TIMEOUT_CYC + 2)}, 32'd1);
    chk("tmo_no_write", act_wr.size(), 0);
    rd_data_q.push_back(8'h55);
    exp_rd.push_back(16'h0009);
    exp_tx.push_back(16'h0055);
    send_byte(8'hBB); send_byte(8'h09);
    wait_sync("tmo_rd_sync");
    cmp_queues("tmo_rd");
`else
    // Without timeout a partial frame waits indefinitely
    clr();
    err_cnt = 0;
    send_byte(8'hAA); send_byte(8'h03);
    repeat (300) @(negedge CLK);
    chk("wait_no_write", act_wr.size(), 0);
    exp_wr.push_back(16'h0366);
    send_byte(8'h66);
    wait_sync("wait_sync");
    cmp_queues("wait");
    chk("no_frame_err", err_cnt, 0);
`endif

    // Reset in the middle of a 0xCC frame
    clr();
    send_byte(8'hCC); send_byte(8'h11);
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("midreset_outputs", outs(), 32'd0);
    @(posedge CLK); #1; RST = 1'b1;
    repeat (2) @(posedge CLK);
    clr();
    exp_wr.push_back(16'h075A);
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h5A);
    wait_sync("post_reset_sync");
    cmp_queues("post_reset");

    // Randomized frames with random backpressure and stray bytes
    clr();
    err_cnt   = 0;
    full_mode = 2;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      fa = 8'($urandom); fb = 8'($urandom); fd = 8'($urandom);
      fn = 8'($urandom); fr = 8'($urandom); fv = 16'($urandom);
      case (kind)
        0: begin
          exp_wr.push_back({4'h0, fa[3:0], fd});
          send_byte(8'hAA); send_byte(fa); send_byte(fd);
        end
        1: begin
          rd_data_q.push_back(fr);
          exp_rd.push_back({12'h000, fa[3:0]});
          exp_tx.push_back({8'h00, fr});
          send_byte(8'hBB); send_byte(fa);
          if ($urandom_range(0, 1) == 1) send_byte(rand_cmd());
        end
        2: begin
          alu_res_q.push_back(fv);
          exp_wr.push_back({8'h00, fa}); exp_wr.push_back({8'h01, fb});
          exp_alu.push_back({12'h000, fn[3:0]});
          for (int i = 0; i < RESB; i++) exp_tx.push_back({8'h00, 8'(fv >> (8 * i))});
          send_byte(8'hCC); send_byte(fa); send_byte(fb); send_byte(fn);
          if ($urandom_range(0, 1) == 1) send_byte(rand_cmd());
        end
        3: begin
          alu_res_q.push_back(fv);
          exp_alu.push_back({12'h000, fn[3:0]});
          for (int i = 0; i < RESB; i++) exp_tx.push_back({8'h00, 8'(fv >> (8 * i))});
          send_byte(8'hDD); send_byte(fn);
          if ($urandom_range(0, 1) == 1) send_byte(rand_cmd());
        end
        default: begin
          fd = 8'($urandom);
          while (fd == 8'hAA || fd == 8'hBB || fd == 8'hCC || fd == 8'hDD) fd = 8'($urandom);
          send_byte(fd);
        end
      endcase
      wait_sync("rand_sync");
    end
    full_mode = 0;
    cmp_queues("rand");
    chk("rand_no_frame_err", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
